msb_word_serializer: RTL and testbench

//  Upstream feeder for the serial divisibility checker (mod-5 remainder FSM).

---
 rtl/msb_word_serializer.sv | 101 ++++++++++
 tb/tb_msb_word_serializer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/msb_word_serializer.sv
`default_nettype none
// ============================================================================
// Module      : msb_word_serializer
// Description : Parallel-word to MSB-first bit stream feeder with checker clear.
// Revision    : 1.0 - initial release
// ============================================================================
module msb_word_serializer #(
  parameter  int WIDTH = 8,
  localparam int LW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LW-1:0]    in_len,
  input  logic             in_first,
  output logic             ser_valid,
  output logic             ser_bit,
  output logic             ser_last,
  output logic             ser_clear_n
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_SHIFT = 2'd2
  } state_t;

  localparam logic [LW-1:0] c_width = LW'(WIDTH);
  localparam logic [LW-1:0] c_one   = LW'(1);
  localparam logic [LW-1:0] c_two   = LW'(2);

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;  // word left-aligned so the next bit is always the MSB
  logic [LW-1:0]    r_cnt;    // bits remaining, including the one on ser_bit

  logic [LW-1:0]    w_len_eff;
  logic [WIDTH-1:0] w_aligned;
  logic             w_final;
  logic             w_accept;

  assign w_len_eff = ((in_len == '0) || (in_len > c_width)) ? c_width : in_len;
  assign w_aligned = in_data << (c_width - w_len_eff);
  assign w_final   = (r_state == S_SHIFT) && (r_cnt == c_one);
  assign in_ready  = resetn && ((r_state == S_IDLE) || w_final);
  assign w_accept  = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_shreg     <= '0;
      r_cnt       <= '0;
      ser_valid   <= 1'b0;
      ser_bit     <= 1'b0;
      ser_last    <= 1'b0;
      ser_clear_n <= 1'b0;
    end else begin
      ser_valid   <= 1'b0;
      ser_bit     <= 1'b0;
      ser_last    <= 1'b0;
      ser_clear_n <= 1'b1;
      case (r_state)
        S_CLEAR: begin
          r_state   <= S_SHIFT;
          ser_valid <= 1'b1;
          ser_bit   <= r_shreg[WIDTH-1];
          ser_last  <= (r_cnt == c_one);
          r_shreg   <= r_shreg << 1;
        end
        default: begin
          if ((r_state == S_SHIFT) && !w_final) begin
            ser_valid <= 1'b1;
            ser_bit   <= r_shreg[WIDTH-1];
            ser_last  <= (r_cnt == c_two);
            r_shreg   <= r_shreg << 1;
            r_cnt     <= r_cnt - c_one;
          end else if (w_accept) begin
            // Final-bit or idle cycle with a word offered: load without a bubble
            r_cnt <= w_len_eff;
            if (in_first) begin
              r_state     <= S_CLEAR;
              r_shreg     <= w_aligned;
              ser_clear_n <= 1'b0;
            end else begin
              r_state   <= S_SHIFT;
              ser_valid <= 1'b1;
              ser_bit   <= w_aligned[WIDTH-1];
              ser_last  <= (w_len_eff == c_one);
              r_shreg   <= w_aligned << 1;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_msb_word_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_msb_word_serializer
// Description : Randomized and directed bench for msb_word_serializer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_msb_word_serializer;

  localparam int WIDTH = 8;
  localparam int LW    = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             resetn;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [LW-1:0]    in_len;
  logic             in_first;
  logic             ser_valid;
  logic             ser_bit;
  logic             ser_last;
  logic             ser_clear_n;

  msb_word_serializer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_len     (in_len),
    .in_first   (in_first),
    .ser_valid  (ser_valid),
    .ser_bit    (ser_bit),
    .ser_last   (ser_last),
    .ser_clear_n(ser_clear_n)
  );

  always #5 clk = ~clk;

  // One expected output slot per cycle: valid, bit, last, clear_n
  typedef struct packed {
    logic v;
    logic b;
    logic l;
    logic cn;
  } slot_t;

  slot_t       exp_q[$];
  int          mod_q[$];
  int          m_val;
  logic        m_ready;
  logic        acc;
  logic        rst_seen;
  int          checks;
  int          errors;
  logic [63:0] obs_val;
  int          obs_mod;
  int          nbits;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Word -> timeline of output slots and expected mod-5 value at word end
  task automatic push_word(input logic [WIDTH-1:0] d, input int l, input logic f);
    int len;
    int masked;
    len = (l == 0 || l > WIDTH) ? WIDTH : l;
    masked = int'(d) & ((1 << len) - 1);
    if (f) exp_q.push_back(4'b0000);
    for (int i = len - 1; i >= 0; i--)
      exp_q.push_back({1'b1, d[i], (i == 0), 1'b1});
    m_val = f ? (masked % 5) : ((m_val * (1 << len) + masked) % 5);
    mod_q.push_back(m_val);
  endtask

  task automatic step();
    slot_t s;
    @(posedge clk);
    acc = 1'b0;
    if (!resetn) begin
      exp_q.delete();
      mod_q.delete();
      m_val    = 0;
      rst_seen = 1'b1;
    end else begin
      rst_seen = 1'b0;
      if (in_valid && m_ready) begin
        acc = 1'b1;
        push_word(in_data, int'(in_len), in_first);
      end
    end
    @(negedge clk);
    if (rst_seen)                s = 4'b0000;
    else if (exp_q.size() > 0)   s = exp_q.pop_front();
    else                         s = 4'b0001;
    chk("ser_valid", {63'd0, ser_valid}, {63'd0, s.v});
    chk("ser_clear_n", {63'd0, ser_clear_n}, {63'd0, s.cn});
    if (s.v || rst_seen) begin
      chk("ser_bit", {63'd0, ser_bit}, {63'd0, s.b});
      chk("ser_last", {63'd0, ser_last}, {63'd0, s.l});
    end
    // Downstream checker behaviour: restart on clear, accumulate on valid
    if (!ser_clear_n) begin
      obs_val = '0;
      obs_mod = 0;
      nbits   = 0;
    end else if (ser_valid) begin
      obs_val = {obs_val[62:0], ser_bit};
      obs_mod = (obs_mod * 2 + int'(ser_bit)) % 5;
      nbits++;
      if (ser_last) begin
        if (mod_q.size() == 0) chk("mod5_unexpected_last", 64'd1, 64'd0);
        else chk("mod5", 64'(obs_mod), 64'(mod_q.pop_front()));
      end
    end
    m_ready = resetn && (exp_q.size() == 0);
    chk("in_ready", {63'd0, in_ready}, {63'd0, m_ready});
  endtask

  task automatic send_word(input logic [WIDTH-1:0] d, input logic [LW-1:0] l, input logic f);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_len   = l;
    in_first = f;
    for (int i = 0; i < 40 && !done; i++) begin
      step();
      done = acc;
    end
    if (!done) chk("accept_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
    in_data  = WIDTH'($urandom);
  endtask

  initial begin
    checks = 0; errors = 0; m_val = 0; m_ready = 1'b0;
    obs_val = '0; obs_mod = 0; nbits = 0; rst_seen = 1'b0; acc = 1'b0;
    resetn = 1'b0; in_valid = 1'b0; in_data = '0; in_len = '0; in_first = 1'b0;
    step(); step();
    resetn = 1'b1;
    step();

    // 0x05 len 3, new number
    send_word(8'h05, 4'd3, 1'b1);
    repeat (5) step();
    chk("t1_value", obs_val, 64'd5);
    chk("t1_nbits", 64'(nbits), 64'd3);
    chk("t1_div5", 64'(obs_val % 5 == 0), 64'd1);

    // 0x01/1 then 0x04/3 back-to-back continue the same number
    send_word(8'h01, 4'd1, 1'b1);
    send_word(8'h04, 4'd3, 1'b0);
    repeat (5) step();
    chk("t2_value", obs_val, 64'd12);
    chk("t2_nbits", 64'(nbits), 64'd4);
    chk("t2_div5", 64'(obs_val % 5 == 0), 64'd0);

    // len 0 means full width
    send_word(8'hA0, 4'd0, 1'b1);
    repeat (10) step();
    chk("t3_value", obs_val, 64'd160);
    chk("t3_nbits", 64'(nbits), 64'd8);

    // Idle with no traffic
    repeat (3) step();
    chk("t4_idle", {61'd0, ser_valid, ser_clear_n, in_ready}, 64'b011);

    // Reset during second bit of a word
    send_word(8'hFF, 4'd8, 1'b0);
    step();
    resetn = 1'b0;
    step();
    chk("t5_in_reset", {60'd0, ser_valid, ser_bit, ser_clear_n, in_ready}, 64'b0000);
    resetn = 1'b1;
    repeat (12) step();
    chk("t5_after", {61'd0, ser_valid, ser_clear_n, in_ready}, 64'b011);

    // Random words, lengths, first flags and gaps
    for (int w = 0; w < 300; w++) begin
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) step();
      send_word(WIDTH'($urandom), LW'($urandom_range(0, WIDTH)), ($urandom_range(0, 9) < 3));
    end
    repeat (20) step();
    chk("drain_empty", 64'(exp_q.size() + mod_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
